// File: rtl/atriusb_fx2_event_writer_pkg.sv
// Shared types and constants for the FX2 event endpoint writer.
package atriusb_fx2_event_writer_pkg;

    localparam int unsigned STATE_W           = 4;
    localparam int unsigned DEBUG_CNT_W       = 10;
    localparam int unsigned PKT_BYTES_DEFAULT = 512;

    // FIFOADR values of the four FX2 slave-FIFO endpoints
    localparam logic [1:0] FX2_EP2_ADDR = 2'b00;
    localparam logic [1:0] FX2_EP4_ADDR = 2'b01;
    localparam logic [1:0] FX2_EP6_ADDR = 2'b10;
    localparam logic [1:0] FX2_EP8_ADDR = 2'b11;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 4'd0,
        ST_REQ     = 4'd1,
        ST_SETUP   = 4'd2,
        ST_STREAM  = 4'd3,
        ST_STALL   = 4'd4,
        ST_FLUSH   = 4'd5,
        ST_GAP     = 4'd6,
        ST_PKTEND  = 4'd7,
        ST_RELEASE = 4'd8
    } state_e;

endpackage

// File: rtl/fx2_pktend_timer.sv
// Idle-gap counter ahead of PKTEND and the registered one-cycle PKTEND pulse.
module fx2_pktend_timer
    import atriusb_fx2_event_writer_pkg::*;
#(
    parameter int unsigned GAP = 3
) (
    input  logic phy_clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic pf_n_i,
    output logic fire_c,
    output logic pktend_n_o
);

    localparam int unsigned CNT_W = (GAP < 3) ? 1 : $clog2(GAP);
    localparam int unsigned LOAD  = (GAP > 0) ? GAP - 1 : 0;

    logic             running;
    logic [CNT_W-1:0] cnt;

    // The start cycle is itself the first idle cycle, so fire when one remains.
    assign fire_c = running && (cnt <= CNT_W'(1)) && pf_n_i;

    always_ff @(posedge phy_clk_i or posedge rst_i) begin
        if (rst_i) begin
            running    <= 1'b0;
            cnt        <= '0;
            pktend_n_o <= 1'b1;
        end else begin
            pktend_n_o <= ~fire_c;
            if (start_i) begin
                running <= 1'b1;
                cnt     <= CNT_W'(LOAD);
            end else if (fire_c) begin
                running <= 1'b0;
            end else if (running && (cnt > CNT_W'(1))) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/atriusb_fx2_event_writer.sv
// Streams readout event bytes into the FX2 slave-FIFO event endpoint,
// arbitrating for the shared FD bus and closing short packets with PKTEND.
module atriusb_fx2_event_writer
    import atriusb_fx2_event_writer_pkg::*;
#(
    parameter logic [1:0]  EP_ADDR    = FX2_EP6_ADDR,
    parameter int unsigned PKT_BYTES  = PKT_BYTES_DEFAULT,
    parameter int unsigned PKTEND_GAP = 3
) (
    input  logic        phy_clk_i,
    input  logic        rst_i,
    input  logic        event_pending_i,
    input  logic        event_done_i,
    input  logic [7:0]  bridge_dat_i,
    output logic        bridge_rd_o,
    output logic        event_pause_o,
    output logic        bus_req_o,
    input  logic        bus_gnt_i,
    input  logic        fx2_pf_n_i,
    output logic [7:0]  fx2_dat_o,
    output logic        fx2_dat_oe_o,
    output logic [1:0]  fx2_fifoadr_o,
    output logic        fx2_slwr_n_o,
    output logic        fx2_pktend_n_o,
    output logic [15:0] debug_o
);

    localparam int unsigned CNT_W = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;

    state_e           state, state_nx;
    logic             rd_c, rd_d;
    logic             oe_nx, bus_req_nx, pause_nx;
    logic             done_q;
    logic             timer_start_c, timer_fire_c;
    logic [CNT_W-1:0] pkt_cnt;

    // Next state, byte request and next values of the bus-control flops
    always_comb begin
        state_nx      = state;
        rd_c          = 1'b0;
        oe_nx         = fx2_dat_oe_o;
        bus_req_nx    = bus_req_o;
        timer_start_c = 1'b0;
        case (state)
            ST_IDLE: begin
                bus_req_nx = 1'b0;
                if (event_pending_i) begin
                    state_nx   = ST_REQ;
                    bus_req_nx = 1'b1;
                end
            end
            ST_REQ: begin
                bus_req_nx = 1'b1;
                if (bus_gnt_i) begin
                    state_nx = ST_SETUP;
                    oe_nx    = 1'b1;
                end
            end
            ST_SETUP: begin
                oe_nx    = 1'b1;
                state_nx = ST_STREAM;
            end
            ST_STREAM: begin
                if (event_done_i || done_q) begin
                    state_nx = ST_FLUSH;
                end else if (!fx2_pf_n_i) begin
                    state_nx = ST_STALL;
                end else if (!bus_gnt_i) begin
                    state_nx = ST_REQ;
                end else begin
                    rd_c = event_pending_i;
                end
            end
            ST_STALL: begin
                if (fx2_pf_n_i && !rd_d && fx2_slwr_n_o) state_nx = ST_STREAM;
            end
            ST_FLUSH: begin
                if (!rd_d && fx2_slwr_n_o) begin
                    if (pkt_cnt != '0) begin
                        state_nx      = ST_GAP;
                        timer_start_c = 1'b1;
                    end else begin
                        state_nx = ST_RELEASE;
                    end
                end
            end
            ST_GAP: begin
                if (timer_fire_c) state_nx = ST_PKTEND;
            end
            ST_PKTEND: begin
                state_nx = ST_RELEASE;
            end
            ST_RELEASE: begin
                oe_nx    = 1'b0;
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
        pause_nx = !((state_nx == ST_STREAM) && fx2_pf_n_i && bus_gnt_i);
    end

    assign bridge_rd_o = rd_c;

    always_ff @(posedge phy_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            fx2_dat_oe_o  <= 1'b0;
            bus_req_o     <= 1'b0;
            event_pause_o <= 1'b1;
            fx2_fifoadr_o <= EP_ADDR;
            debug_o       <= '0;
        end else begin
            state         <= state_nx;
            fx2_dat_oe_o  <= oe_nx;
            bus_req_o     <= bus_req_nx;
            event_pause_o <= pause_nx;
            fx2_fifoadr_o <= EP_ADDR;
            debug_o       <= {DEBUG_CNT_W'(pkt_cnt), ~fx2_slwr_n_o, rd_c, state};
        end
    end

    // A done pulse seen while stalled or re-arbitrating must not be lost
    always_ff @(posedge phy_clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_q <= 1'b0;
        end else if ((state == ST_IDLE) || (state == ST_FLUSH)) begin
            done_q <= 1'b0;
        end else if (event_done_i) begin
            done_q <= 1'b1;
        end
    end

    // Write pipeline: request, data capture, SLWR; full packets wrap silently
    always_ff @(posedge phy_clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_d         <= 1'b0;
            fx2_slwr_n_o <= 1'b1;
            fx2_dat_o    <= '0;
            pkt_cnt      <= '0;
        end else begin
            rd_d         <= rd_c;
            fx2_slwr_n_o <= ~rd_d;
            if (rd_d) fx2_dat_o <= bridge_dat_i;
            if (state == ST_PKTEND) begin
                pkt_cnt <= '0;
            end else if (rd_d) begin
                pkt_cnt <= pkt_cnt + CNT_W'(1);
            end
        end
    end

    fx2_pktend_timer #(
        .GAP (PKTEND_GAP)
    ) u_pktend_timer (
        .phy_clk_i  (phy_clk_i),
        .rst_i      (rst_i),
        .start_i    (timer_start_c),
        .pf_n_i     (fx2_pf_n_i),
        .fire_c     (timer_fire_c),
        .pktend_n_o (fx2_pktend_n_o)
    );

endmodule

// File: tb/tb_atriusb_fx2_event_writer.sv
// Directed-random bench for the FX2 event writer with a readout/FX2 model.
module tb_atriusb_fx2_event_writer;

    localparam int unsigned PKT = 512;
    localparam int unsigned GAP = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        pending;
    logic        done;
    logic [7:0]  bdat;
    logic        gnt;
    logic        pf;
    logic        bridge_rd_o;
    logic        event_pause_o;
    logic        bus_req_o;
    logic [7:0]  fx2_dat_o;
    logic        fx2_dat_oe_o;
    logic [1:0]  fx2_fifoadr_o;
    logic        fx2_slwr_n_o;
    logic        fx2_pktend_n_o;
    logic [15:0] debug_o;

    always #5 clk = ~clk;

    atriusb_fx2_event_writer #(
        .EP_ADDR    (2'b10),
        .PKT_BYTES  (PKT),
        .PKTEND_GAP (GAP)
    ) dut (
        .phy_clk_i       (clk),
        .rst_i           (rst),
        .event_pending_i (pending),
        .event_done_i    (done),
        .bridge_dat_i    (bdat),
        .bridge_rd_o     (bridge_rd_o),
        .event_pause_o   (event_pause_o),
        .bus_req_o       (bus_req_o),
        .bus_gnt_i       (gnt),
        .fx2_pf_n_i      (pf),
        .fx2_dat_o       (fx2_dat_o),
        .fx2_dat_oe_o    (fx2_dat_oe_o),
        .fx2_fifoadr_o   (fx2_fifoadr_o),
        .fx2_slwr_n_o    (fx2_slwr_n_o),
        .fx2_pktend_n_o  (fx2_pktend_n_o),
        .debug_o         (debug_o)
    );

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         last_wr_cyc = -10;
    int         runs = 0;
    int         pk_n = 0;
    int         pk_cyc = 0;
    int         overread = 0;
    logic [7:0] wr_q[$];
    int         len_req = 0;
    logic [7:0] base_req = 8'd0;
    int         go = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Readout source and FX2 endpoint model: serves bytes on request, records writes
    initial begin : env
        int         rem;
        int         go_seen;
        logic [7:0] nxt;
        logic       rd_s;
        rem = 0; go_seen = 0; nxt = 8'd0;
        pending = 1'b0; done = 1'b0; bdat = 8'd0;
        forever begin
            @(negedge clk);
            cyc++;
            rd_s = bridge_rd_o;
            if (fx2_slwr_n_o === 1'b0) begin
                wr_q.push_back(fx2_dat_o);
                if (last_wr_cyc != cyc - 1) runs++;
                last_wr_cyc = cyc;
            end
            if (fx2_pktend_n_o === 1'b0) begin
                pk_n++;
                pk_cyc = cyc;
            end
            @(posedge clk);
            #1;
            done = 1'b0;
            bdat = 8'($urandom);
            if (rst === 1'b1) begin
                rem = 0;
            end else begin
                if (go != go_seen) begin
                    go_seen = go;
                    rem     = len_req;
                    nxt     = base_req;
                end
                if (rd_s === 1'b1) begin
                    if (rem == 0) begin
                        overread++;
                    end else begin
                        bdat = nxt;
                        nxt  = nxt + 8'd1;
                        rem--;
                        done = (rem == 0);
                    end
                end
            end
            pending = (rem > 0);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_event(input int len, input logic [7:0] base);
        len_req  = len;
        base_req = base;
        go++;
    endtask

    task automatic wait_writes(input int wb, input int k, input string tag);
        int n;
        n = 0;
        while ((wr_q.size() - wb) < k && n < 5000) begin
            cycles(1);
            n++;
        end
        chk(tag, 32'(n < 5000), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus_req_o !== 1'b1 && n < 100) begin
            cycles(1);
            n++;
        end
        while (!(bus_req_o === 1'b0 && fx2_dat_oe_o === 1'b0) && n < 5000) begin
            cycles(1);
            n++;
        end
        chk(tag, 32'(n < 5000), 32'd1);
        cycles(4);
    endtask

    task automatic check_data(input int wb, input int len, input logic [7:0] base, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < len && (wb + i) < wr_q.size(); i++) begin
            if (wr_q[wb + i] !== 8'(int'(base) + i)) bad++;
        end
        chk({tag, "_count"}, 32'(wr_q.size() - wb), 32'(len));
        chk({tag, "_order"}, 32'(bad), 32'd0);
    endtask

    initial begin : main
        int         wb, pb, rb, len, k, w0, w1, rel, n;
        logic [7:0] b;
        rst = 1'b1; gnt = 1'b1; pf = 1'b1;
        cycles(3);
        chk("rst_rd",      32'(bridge_rd_o),    32'd0);
        chk("rst_bus_req", 32'(bus_req_o),      32'd0);
        chk("rst_oe",      32'(fx2_dat_oe_o),   32'd0);
        chk("rst_pause",   32'(event_pause_o),  32'd1);
        chk("rst_slwr",    32'(fx2_slwr_n_o),   32'd1);
        chk("rst_pktend",  32'(fx2_pktend_n_o), 32'd1);
        chk("rst_fifoadr", 32'(fx2_fifoadr_o),  32'd2);
        chk("rst_dat",     32'(fx2_dat_o),      32'd0);
        chk("rst_debug",   32'(debug_o),        32'd0);
        rst = 1'b0;
        cycles(3);

        // Exactly two full packets: autocommitted, no PKTEND, back-to-back writes
        wb = wr_q.size(); pb = pk_n; rb = runs; b = 8'($urandom);
        start_event(1024, b);
        wait_idle("t1_idle");
        check_data(wb, 1024, b, "t1");
        chk("t1_runs",    32'(runs - rb),     32'd1);
        chk("t1_pktend",  32'(pk_n - pb),     32'd0);
        chk("t1_pkt_cnt", 32'(debug_o[15:6]), 32'd0);
        chk("t1_bus_req", 32'(bus_req_o),     32'd0);

        // Short trailing packet: one PKTEND pulse after exactly GAP idle cycles
        wb = wr_q.size(); pb = pk_n; b = 8'($urandom);
        start_event(1030, b);
        wait_idle("t2_idle");
        check_data(wb, 1030, b, "t2");
        chk("t2_pktend",  32'(pk_n - pb),                32'd1);
        chk("t2_gap",     32'(pk_cyc - last_wr_cyc - 1), 32'(GAP));
        chk("t2_pkt_cnt", 32'(debug_o[15:6]),            32'd0);

        // Almost-full for 20 cycles mid-event
        wb = wr_q.size(); pb = pk_n; b = 8'($urandom);
        len = $urandom_range(200, 400); k = $urandom_range(30, 150);
        start_event(len, b);
        wait_writes(wb, k, "t3_reach");
        pf = 1'b0;
        w0 = wr_q.size();
        cycles(3);
        chk("t3_pause", 32'(event_pause_o), 32'd1);
        cycles(17);
        w1 = wr_q.size();
        chk("t3_inflight", 32'((w1 - w0) <= 2), 32'd1);
        pf = 1'b1;
        wait_idle("t3_idle");
        check_data(wb, len, b, "t3");
        chk("t3_pktend", 32'(pk_n - pb), 32'(len % PKT != 0));

        // Grant withdrawn for 10 cycles mid-event
        wb = wr_q.size(); pb = pk_n; b = 8'($urandom);
        len = $urandom_range(200, 400); k = $urandom_range(30, 150);
        start_event(len, b);
        wait_writes(wb, k, "t4_reach");
        gnt = 1'b0;
        #1;
        chk("t4_rd_drop", 32'(bridge_rd_o), 32'd0);
        cycles(5);
        chk("t4_oe_held", 32'(fx2_dat_oe_o),  32'd1);
        chk("t4_bus_req", 32'(bus_req_o),     32'd1);
        chk("t4_pause",   32'(event_pause_o), 32'd1);
        cycles(5);
        gnt = 1'b1;
        wait_idle("t4_idle");
        check_data(wb, len, b, "t4");
        chk("t4_pktend", 32'(pk_n - pb), 32'(len % PKT != 0));

        // Done coincident with almost-full on a 7-byte event
        wb = wr_q.size(); pb = pk_n; b = 8'($urandom);
        start_event(7, b);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (done === 1'b1) break;
            n++;
        end
        chk("t5_done_seen", 32'(n < 200), 32'd1);
        pf = 1'b0;
        cycles(15);
        chk("t5_no_early_pktend", 32'(pk_n - pb),     32'd0);
        chk("t5_pktend_high",     32'(fx2_pktend_n_o), 32'd1);
        pf = 1'b1;
        rel = cyc;
        wait_idle("t5_idle");
        check_data(wb, 7, b, "t5");
        chk("t5_pktend",     32'(pk_n - pb),     32'd1);
        chk("t5_after_flag", 32'(pk_cyc > rel),  32'd1);

        // Reset mid-stream, then a full-packet event must see a clean counter
        wb = wr_q.size(); b = 8'($urandom);
        start_event(600, b);
        wait_writes(wb, $urandom_range(20, 300), "t6_reach");
        rst = 1'b1;
        #1;
        chk("t6_slwr",    32'(fx2_slwr_n_o),   32'd1);
        chk("t6_pktend",  32'(fx2_pktend_n_o), 32'd1);
        chk("t6_oe",      32'(fx2_dat_oe_o),   32'd0);
        chk("t6_rd",      32'(bridge_rd_o),    32'd0);
        chk("t6_bus_req", 32'(bus_req_o),      32'd0);
        cycles(3);
        chk("t6_debug", 32'(debug_o), 32'd0);
        rst = 1'b0;
        cycles(3);
        wb = wr_q.size(); pb = pk_n; b = 8'($urandom);
        start_event(512, b);
        wait_idle("t6_idle");
        check_data(wb, 512, b, "t6");
        chk("t6_no_pktend", 32'(pk_n - pb),     32'd0);
        chk("t6_pkt_cnt",   32'(debug_o[15:6]), 32'd0);

        chk("overread", 32'(overread), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
